// File: rtl/init_bus_frontend_pkg.sv
// init_bus_frontend_pkg: shared FSM states, widths, arbiter and target encodings.
// With FRONTEND_SPLIT_EN defined the initiator FSM gains the SPLIT_WAIT state.
package init_bus_frontend_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WAIT_RESP,
        S_RECV
`ifdef FRONTEND_SPLIT_EN
        , S_SPLIT_WAIT
`endif
    } init_state_e;
    localparam logic [1:0] SEL_IDLE  = 2'b00;
    localparam logic [1:0] SEL_I1    = 2'b01;
    localparam logic [1:0] SEL_I2    = 2'b10;
    localparam logic [1:0] SEL_SPLIT = 2'b11;
    localparam logic [1:0] TGT1_PFX  = 2'b00;
    localparam logic [1:0] TGT2_PFX  = 2'b01;
    localparam logic [1:0] TGT3_PFX  = 2'b10;
endpackage

// File: rtl/init_bus_frontend_bit_deserializer.sv
// bit_deserializer: MSB-first shift register; the full word is held in data_o
// and done_o pulses for one cycle after the N-th accepted bit.
module bit_deserializer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bit_i,
    input  logic         valid_i,
    output logic [N-1:0] data_o,
    output logic         done_o
);
    localparam int CW = $clog2(N);
    logic [CW-1:0] cnt_q;
    logic [N-2:0]  shift_q;
    logic [N-1:0]  data_q;
    logic          done_q;
    logic          last;
    logic [N-1:0]  word;
    assign last   = valid_i && cnt_q == CW'(N - 1);
    assign word   = {shift_q, bit_i};
    assign data_o = data_q;
    assign done_o = done_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= last ? '0 : cnt_q + CW'(valid_i);
            shift_q <= valid_i ? word[N-2:0] : shift_q;
            data_q  <= last ? word : data_q;
            done_q  <= last;
        end
    end
endmodule

// File: rtl/init_bus_frontend.sv
// init_bus_frontend: initiator port, fixed-priority arbiter and address decoder.
// FRONTEND_SPLIT_EN enables split responses, the split grant and the decoder hold.
module init_bus_frontend
    import init_bus_frontend_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_req,
    input  logic [15:0] init_addr_out,
    input  logic        init_addr_out_valid,
    input  logic [7:0]  init_data_out,
    input  logic        init_data_out_valid,
    input  logic        init_rw,
    input  logic        init_ready,
    input  logic        target_split,
    input  logic        target_ack,
    input  logic        bus_data_in,
    input  logic        bus_data_in_valid,
    input  logic        req_i_2,
    input  logic        req_split,
    input  logic        split,
    output logic        bus_data_out,
    output logic        bus_data_out_valid,
    output logic        bus_mode,
    output logic        init_grant,
    output logic [7:0]  init_data_in,
    output logic        init_data_in_valid,
    output logic        init_ack,
    output logic        init_split_ack,
    output logic        bus_init_ready,
    output logic        bus_init_rw,
    output logic        grant_i_2,
    output logic        grant_split,
    output logic [1:0]  arb_sel,
    output logic        target_1_valid,
    output logic        target_2_valid,
    output logic        target_3_valid,
    output logic [1:0]  dec_sel
);
    init_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, dec_word;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        owner_q, owner_d;
    logic rw_q, ack_q, split_ack_q, ready_q, hold_q;
    logic busy, last_bit, keep, req_i_1, grant_i_1;
    logic in_split_wait, req_split_en, split_hold, go_split;
    logic dec_accept, dec_done, dec_on, rx_accept;
    logic unused_word;
`ifdef FRONTEND_SPLIT_EN
    assign in_split_wait = state_q == S_SPLIT_WAIT;
    assign req_split_en  = req_split;
    assign split_hold    = split;
    assign go_split      = state_q == S_WAIT_RESP && target_split && !bus_data_in_valid;
`else
    logic unused_split;
    assign unused_split  = ^{target_split, req_split, split};
    assign in_split_wait = 1'b0;
    assign req_split_en  = 1'b0;
    assign split_hold    = 1'b0;
    assign go_split      = 1'b0;
`endif
    assign busy     = state_q == S_ADDR || state_q == S_DATA;
    assign last_bit = (state_q == S_ADDR && cnt_q == 4'(ADDR_W - 1)) ||
                      (state_q == S_DATA && cnt_q == 4'(DATA_W - 1));
    assign cnt_d    = (busy && !last_bit) ? cnt_q + 4'd1 : 4'd0;
    // The request is held through the serial burst so a dropped init_req never truncates it.
    assign req_i_1   = !in_split_wait && (init_req || busy);
    assign grant_i_1 = owner_q == SEL_I1;
    assign keep = (owner_q == SEL_SPLIT && req_split_en) ||
                  (owner_q == SEL_I1 && req_i_1) ||
                  (owner_q == SEL_I2 && req_i_2);
    assign owner_d = keep ? owner_q : req_split_en ? SEL_SPLIT : req_i_1 ? SEL_I1 :
                     req_i_2 ? SEL_I2 : SEL_IDLE;
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (grant_i_1 && init_req) state_d = S_ADDR;
            S_ADDR:      if (last_bit) state_d = rw_q ? S_DATA : S_WAIT_RESP;
            S_DATA:      if (last_bit) state_d = S_IDLE;
            S_WAIT_RESP: if (bus_data_in_valid) state_d = S_RECV;
`ifdef FRONTEND_SPLIT_EN
                         else if (target_split) state_d = S_SPLIT_WAIT;
            S_SPLIT_WAIT: if (bus_data_in_valid) state_d = S_RECV;
`endif
            S_RECV:      if (init_data_in_valid) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            owner_q     <= SEL_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            rw_q        <= 1'b0;
            ack_q       <= 1'b0;
            split_ack_q <= 1'b0;
            ready_q     <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            addr_q      <= init_addr_out_valid ? init_addr_out : addr_q;
            data_q      <= init_data_out_valid ? init_data_out : data_q;
            rw_q        <= (state_q == S_IDLE && state_d == S_ADDR) ? init_rw : rw_q;
            ack_q       <= target_ack;
            split_ack_q <= go_split;
            ready_q     <= init_ready;
            hold_q      <= dec_accept ? 1'b0 : (dec_done | hold_q);
        end
    end
    assign bus_data_out_valid = busy;
    assign bus_mode           = state_q == S_ADDR;
    assign bus_data_out       = state_q == S_ADDR ? addr_q[4'(ADDR_W - 1) - cnt_q] :
                                state_q == S_DATA ? data_q[3'(DATA_W - 1) - cnt_q[2:0]] : 1'b0;
    assign init_grant     = grant_i_1;
    assign grant_i_2      = owner_q == SEL_I2;
    assign grant_split    = owner_q == SEL_SPLIT;
    assign arb_sel        = owner_q;
    assign init_ack       = ack_q;
    assign init_split_ack = split_ack_q;
    assign bus_init_ready = ready_q;
    assign bus_init_rw    = rw_q;
    assign dec_accept = bus_data_out_valid && bus_mode && !split_hold;
    assign rx_accept  = bus_data_in_valid &&
                        (state_q == S_WAIT_RESP || state_q == S_RECV || in_split_wait);
    bit_deserializer #(.N(ADDR_W)) u_dec (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_i   (bus_data_out),
        .valid_i (dec_accept),
        .data_o  (dec_word),
        .done_o  (dec_done)
    );
    bit_deserializer #(.N(DATA_W)) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_i   (bus_data_in),
        .valid_i (rx_accept),
        .data_o  (init_data_in),
        .done_o  (init_data_in_valid)
    );
    // Selection stays up from the cycle after the 16th bit until the next address bit.
    assign unused_word    = ^dec_word[ADDR_W-3:0];
    assign dec_on         = dec_done | hold_q;
    assign dec_sel        = dec_word[ADDR_W-1:ADDR_W-2];
    assign target_1_valid = dec_on && dec_sel == TGT1_PFX;
    assign target_2_valid = dec_on && dec_sel == TGT2_PFX;
    assign target_3_valid = dec_on && dec_sel == TGT3_PFX;
endmodule

// File: tb/tb_init_bus_frontend.sv
// tb_init_bus_frontend: vector table, hand sequences and random transfers against a stream/decode model.
module tb_init_bus_frontend;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        init_req = 0, init_addr_out_valid = 0, init_data_out_valid = 0, init_rw = 0;
    logic        init_ready = 0, target_split = 0, target_ack = 0, bus_data_in = 0;
    logic        bus_data_in_valid = 0, req_i_2 = 0, req_split = 0, split = 0;
    logic [15:0] init_addr_out = 0;
    logic [7:0]  init_data_out = 0;
    logic        bus_data_out, bus_data_out_valid, bus_mode, init_grant, init_data_in_valid;
    logic        init_ack, init_split_ack, bus_init_ready, bus_init_rw, grant_i_2, grant_split;
    logic        target_1_valid, target_2_valid, target_3_valid;
    logic [7:0]  init_data_in;
    logic [1:0]  arb_sel, dec_sel;
    logic [25:0] all_out;
    int          n_checks = 0, n_fail = 0;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [4:0]  exp;
    } vec_t;
    vec_t        tbl[4];
    logic [4:0]  snap;
    logic        r_rw;
    logic [15:0] r_addr;
    logic [7:0]  r_data;
    int          nv;

    always #5 clk = ~clk;

    init_bus_frontend dut (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_addr_out(init_addr_out),
        .init_addr_out_valid(init_addr_out_valid), .init_data_out(init_data_out),
        .init_data_out_valid(init_data_out_valid), .init_rw(init_rw), .init_ready(init_ready),
        .target_split(target_split), .target_ack(target_ack), .bus_data_in(bus_data_in),
        .bus_data_in_valid(bus_data_in_valid), .req_i_2(req_i_2), .req_split(req_split),
        .split(split), .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid),
        .bus_mode(bus_mode), .init_grant(init_grant), .init_data_in(init_data_in),
        .init_data_in_valid(init_data_in_valid), .init_ack(init_ack),
        .init_split_ack(init_split_ack), .bus_init_ready(bus_init_ready),
        .bus_init_rw(bus_init_rw), .grant_i_2(grant_i_2), .grant_split(grant_split),
        .arb_sel(arb_sel), .target_1_valid(target_1_valid), .target_2_valid(target_2_valid),
        .target_3_valid(target_3_valid), .dec_sel(dec_sel)
    );

    assign all_out = {bus_data_out, bus_data_out_valid, bus_mode, init_grant, init_data_in,
                      init_data_in_valid, init_ack, init_split_ack, bus_init_ready, bus_init_rw,
                      grant_i_2, grant_split, arb_sel, target_1_valid, target_2_valid,
                      target_3_valid, dec_sel};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode: top two address bits pick the target, 3 means none.
    function automatic logic [4:0] exp_dec(input logic [15:0] a);
        int p;
        p = int'(a) / 16384;
        return {p == 0, p == 1, p == 2, 2'(p)};
    endfunction

    task automatic do_xfer(input logic rw, input logic [15:0] addr, input logic [7:0] data,
                           input bit hold, output logic [4:0] dsnap);
        bit [1:0] exp_q[$];
        bit [1:0] got_q[$];
        int first_c = -1;
        int bad = 0;
        bit taken = 0;
        for (int i = 15; i >= 0; i--) exp_q.push_back({1'b1, addr[i]});
        if (rw) for (int i = 7; i >= 0; i--) exp_q.push_back({1'b0, data[i]});
        dsnap = '0;
        @(negedge clk);
        @(negedge clk);
        init_addr_out = addr; init_addr_out_valid = 1;
        init_data_out = data; init_data_out_valid = 1;
        init_rw = rw; init_req = 1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            init_addr_out_valid = 0; init_data_out_valid = 0;
            if (c == 0) check("grant_latency", init_grant, 1);
            if (got_q.size() == 16 && !taken) begin
                dsnap = {target_1_valid, target_2_valid, target_3_valid, dec_sel};
                taken = 1;
            end
            if (bus_data_out_valid) begin
                if (first_c < 0) first_c = c;
                got_q.push_back({bus_mode, bus_data_out});
                if (!hold) init_req = 0;
            end else if (taken) break;
        end
        check("first_bit_latency", first_c, 1);
        check("stream_len", got_q.size(), exp_q.size());
        foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] != exp_q[i]) bad++;
        check("stream_bits", bad, 0);
        check("bus_init_rw", bus_init_rw, rw);
    endtask

    task automatic rx_byte(input logic [7:0] d);
        int pulses;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            bus_data_in = d[i]; bus_data_in_valid = 1;
        end
        @(negedge clk);
        bus_data_in_valid = 0;
        check("rx_valid_latency", init_data_in_valid, 1);
        check("rx_data", init_data_in, d);
        pulses = init_data_in_valid;
        repeat (4) begin
            @(negedge clk);
            pulses += init_data_in_valid;
        end
        check("rx_valid_pulses", pulses, 1);
    endtask

    initial begin
        tbl[0] = '{1'b1, 16'h800A, 8'h5C, 5'b001_10};
        tbl[1] = '{1'b1, 16'h1234, 8'hA5, 5'b100_00};
        tbl[2] = '{1'b0, 16'h4000, 8'h96, 5'b010_01};
        tbl[3] = '{1'b1, 16'hC000, 8'h3C, 5'b000_11};
        init_ready = 1;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_out, 0);
        rst_n = 1;
        @(negedge clk);
        check("ready_forward", bus_init_ready, 1);

        foreach (tbl[i]) begin
            do_xfer(tbl[i].rw, tbl[i].addr, tbl[i].data, 0, snap);
            check("decode", snap, tbl[i].exp);
            if (!tbl[i].rw) rx_byte(tbl[i].data);
        end

        @(negedge clk); target_ack = 1;
        @(negedge clk); target_ack = 0;
        check("init_ack_pulse", init_ack, 1);
        @(negedge clk);
        check("init_ack_clear", init_ack, 0);

`ifdef FRONTEND_SPLIT_EN
        do_xfer(1'b0, 16'h800A, 8'h00, 1, snap);
        check("split_read_decode", snap, 5'b001_10);
        check("grant_in_wait", init_grant, 1);
        target_split = 1;
        @(negedge clk); target_split = 0;
        check("split_ack_pulse", init_split_ack, 1);
        @(negedge clk);
        check("split_ack_once", init_split_ack, 0);
        check("req_i_1_drops", init_grant, 0);
        init_req = 0; req_split = 1;
        @(negedge clk);
        check("split_grant", {grant_split, arb_sel}, 3'b1_11);
        rx_byte(8'h5C);
        req_split = 0;
        split = 1;
        do_xfer(1'b1, 16'h1234, 8'h11, 0, snap);
        check("decoder_split_hold", snap, 5'b001_10);
        split = 0;
`else
        @(negedge clk); req_split = 1; target_split = 1;
        @(negedge clk);
        @(negedge clk);
        check("split_disabled", {grant_split, init_split_ack, arb_sel}, 0);
        req_split = 0; target_split = 0;
`endif

        @(negedge clk);
        @(negedge clk);
        init_rw = 1; init_req = 1; req_i_2 = 1;
`ifdef FRONTEND_SPLIT_EN
        req_split = 1;
        @(negedge clk);
        check("arb_split_first", {grant_split, init_grant, grant_i_2, arb_sel}, 5'b100_11);
        req_split = 0;
`endif
        @(negedge clk);
        check("arb_init_next", {grant_split, init_grant, grant_i_2, arb_sel}, 5'b010_01);
        @(negedge clk);
        init_req = 0;
        nv = bus_data_out_valid;
        for (int c = 0; c < 60 && !grant_i_2; c++) begin
            @(negedge clk);
            nv += bus_data_out_valid;
        end
        check("arb_i2_last", {grant_split, init_grant, grant_i_2, arb_sel}, 5'b001_10);
        check("write_len_before_release", nv, 24);
        req_i_2 = 0;
        @(negedge clk);
        check("arb_idle", arb_sel, 0);

        for (int k = 0; k < 12; k++) begin
            r_rw = 1'($urandom_range(0, 1));
            r_addr = 16'($urandom);
            r_data = 8'($urandom);
            do_xfer(r_rw, r_addr, r_data, 0, snap);
            check("rand_decode", snap, exp_dec(r_addr));
            if (!r_rw) rx_byte(r_data);
        end

        @(negedge clk);
        init_addr_out = 16'h800A; init_addr_out_valid = 1;
        init_data_out = 8'h5C; init_data_out_valid = 1;
        init_rw = 1; init_req = 1;
        @(negedge clk);
        init_addr_out_valid = 0; init_data_out_valid = 0;
        for (int c = 0; c < 10 && !bus_data_out_valid; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("bit5_on_bus", {bus_data_out_valid, bus_mode}, 2'b11);
        #1 rst_n = 0; init_req = 0;
        #1 check("async_reset_outputs", all_out, 0);
        @(negedge clk);
        rst_n = 1;
        do_xfer(1'b1, 16'h800A, 8'h5C, 0, snap);
        check("post_reset_decode", snap, 5'b001_10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
